recirc_ctrl: RTL and testbench

RECIRC_CTRL -- requirements
Module: recirc_ctrl

---
 rtl/recirc_pkg.sv | 27 ++
 rtl/rr_arbiter4.sv | 29 ++
 rtl/recirc_ctrl.sv | 110 +++++++++++
 tb/tb_recirc_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/recirc_pkg.sv
// Shared definitions for the recirculator controller.
// Contents: lane/threshold width defaults, FSM state encoding, and a helper
// that turns a one-hot lane grant into its lane index.
package recirc_pkg;

    localparam int unsigned NLanesDefault = 4;
    localparam int unsigned UwDefault     = 3;

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    // One-hot (4 lanes) to lane index; zero input maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-lane round-robin arbiter (purely combinational).
// Ports:
//   req        - per-lane request (1 = lane has data)
//   last_grant - index of the lane granted most recently
//   grant      - one-hot grant of the first requesting lane searched from
//                (last_grant + 1) mod 4, or zero when nothing requests
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] grant
);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant = 4'b0000;
        found = 1'b0;
        idx   = 2'd0;
        // The 2-bit add wraps, so i = 4 lands back on last_grant itself.
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/recirc_ctrl.sv
// Recirculator controller: configures FIFO thresholds, then round-robins
// read strobes over the non-empty source lanes while no downstream FIFO is
// almost full. Any FIFO error parks the block in a sticky ERROR state.
// Ports:
//   clk_1, reset_L                  - clock, async active-low reset
//   init                            - request (re)configuration
//   umbral_low_in, umbral_high_in   - thresholds captured while in INIT
//   fifo_empty                      - per-lane source FIFO empty flags
//   fifo_almost_full                - per-lane downstream almost-full flags
//   fifo_error                      - per-lane overflow/underflow flags
//   pop                             - one-hot (or zero) source read strobe
//   selector_IDLE                   - 0 recirculate, 1 forward
//   umbral_low_out, umbral_high_out - latched thresholds
//   state                           - current FSM state
//   idle_out, active_out, error_out - registered state flags
module recirc_ctrl
    import recirc_pkg::*;
#(
    parameter int unsigned NLANES = NLanesDefault,
    parameter int unsigned UW     = UwDefault
) (
    input  logic              clk_1,
    input  logic              reset_L,
    input  logic              init,
    input  logic [UW-1:0]     umbral_low_in,
    input  logic [UW-1:0]     umbral_high_in,
    input  logic [NLANES-1:0] fifo_empty,
    input  logic [NLANES-1:0] fifo_almost_full,
    input  logic [NLANES-1:0] fifo_error,
    output logic [NLANES-1:0] pop,
    output logic              selector_IDLE,
    output logic [UW-1:0]     umbral_low_out,
    output logic [UW-1:0]     umbral_high_out,
    output logic [2:0]        state,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out
);

    state_e     state_q, state_d;
    logic [1:0] last_grant_q;
    logic [3:0] grant;
    logic       all_empty;
    logic       any_error;

    assign all_empty = &fifo_empty;
    assign any_error = |fifo_error;
    assign state     = state_q;

    rr_arbiter4 u_arb (
        .req        (~fifo_empty),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Combinational strobe; it follows state_q, so an async reset kills it
    // immediately without waiting for an edge.
    assign pop = (state_q == StActive && fifo_almost_full == '0) ? grant : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (any_error)  state_d = StError;
                else if (!init) state_d = StIdle;
            end
            StIdle: begin
                if (any_error)       state_d = StError;
                else if (init)       state_d = StInit;
                else if (!all_empty) state_d = StActive;
            end
            StActive: begin
                if (any_error)      state_d = StError;
                else if (init)      state_d = StInit;
                else if (all_empty) state_d = StIdle;
            end
            StError: state_d = StError;
            default: state_d = StReset;
        endcase
    end

    // Flags decode the next state so they line up with state on every cycle.
    always_ff @(posedge clk_1 or negedge reset_L) begin
        if (!reset_L) begin
            state_q         <= StReset;
            selector_IDLE   <= 1'b0;
            umbral_low_out  <= '0;
            umbral_high_out <= '0;
            last_grant_q    <= 2'd3;
            idle_out        <= 1'b0;
            active_out      <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            state_q       <= state_d;
            selector_IDLE <= (state_d == StActive);
            idle_out      <= (state_d == StIdle);
            active_out    <= (state_d == StActive);
            error_out     <= (state_d == StError);
            if (state_q == StInit) begin
                umbral_low_out  <= umbral_low_in;
                umbral_high_out <= umbral_high_in;
            end
            if (|pop) begin
                last_grant_q <= onehot_to_idx(pop);
            end
        end
    end

endmodule

// File: tb/tb_recirc_ctrl.sv
module tb_recirc_ctrl;

    logic       clk_1 = 1'b0;
    logic       reset_L;
    logic       init;
    logic [2:0] umbral_low_in, umbral_high_in;
    logic [3:0] fifo_empty, fifo_almost_full, fifo_error;
    logic [3:0] pop;
    logic       selector_IDLE;
    logic [2:0] umbral_low_out, umbral_high_out;
    logic [2:0] state;
    logic       idle_out, active_out, error_out;

    int checks = 0;
    int errors = 0;

    recirc_ctrl dut (
        .clk_1            (clk_1),
        .reset_L          (reset_L),
        .init             (init),
        .umbral_low_in    (umbral_low_in),
        .umbral_high_in   (umbral_high_in),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_error       (fifo_error),
        .pop              (pop),
        .selector_IDLE    (selector_IDLE),
        .umbral_low_out   (umbral_low_out),
        .umbral_high_out  (umbral_high_out),
        .state            (state),
        .idle_out         (idle_out),
        .active_out       (active_out),
        .error_out        (error_out)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    initial begin
        reset_L          = 1'b0;
        init             = 1'b0;
        umbral_low_in    = 3'd0;
        umbral_high_in   = 3'd0;
        fifo_empty       = 4'hF;
        fifo_almost_full = 4'h0;
        fifo_error       = 4'h0;
        #12;
        check("rst_state", 8'(state), 8'd0);
        check("rst_pop", 8'(pop), 8'h0);
        check("rst_sel", 8'(selector_IDLE), 8'd0);
        check("rst_ulo", 8'(umbral_low_out), 8'd0);
        check("rst_uhi", 8'(umbral_high_out), 8'd0);
        check("rst_flags", 8'({idle_out, active_out, error_out}), 8'd0);

        // Bring-up: RESET -> INIT -> INIT -> IDLE, thresholds 2/6.
        init           = 1'b1;
        umbral_low_in  = 3'd2;
        umbral_high_in = 3'd6;
        @(negedge clk_1);
        reset_L = 1'b1;
        tick();
        check("bu_init1", 8'(state), 8'd1);
        tick();
        check("bu_init2", 8'(state), 8'd1);
        init = 1'b0;
        tick();
        check("bu_idle", 8'(state), 8'd2);
        check("bu_idle_flag", 8'({idle_out, active_out, error_out}), 8'b100);
        check("bu_ulo", 8'(umbral_low_out), 8'd2);
        check("bu_uhi", 8'(umbral_high_out), 8'd6);

        // Thresholds must hold outside INIT.
        umbral_low_in  = 3'd5;
        umbral_high_in = 3'd1;
        tick();
        check("hold_ulo", 8'(umbral_low_out), 8'd2);
        check("hold_uhi", 8'(umbral_high_out), 8'd6);
        check("idle_pop", 8'(pop), 8'h0);

        // Rotation over all lanes, starting after last_grant=3.
        fifo_empty = 4'b0000;
        tick();
        check("act_state", 8'(state), 8'd3);
        check("act_flag", 8'({idle_out, active_out, error_out}), 8'b010);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rot%0d", i), 8'(pop), 8'(4'b0001 << (i % 4)));
            check($sformatf("rot_sel%0d", i), 8'(selector_IDLE), 8'd1);
            tick();
        end
        check("rot_wrap", 8'(pop), 8'h1);
        tick();

        // Sparse lanes, last_grant=0: lanes 0 and 2 have data.
        fifo_empty = 4'b1010;
        #1;
        check("sparse0", 8'(pop), 8'h4);
        tick();
        check("sparse1", 8'(pop), 8'h1);
        tick();
        check("sparse2", 8'(pop), 8'h4);
        tick();

        // Stall with last_grant=2, then resume at lane 3.
        fifo_empty       = 4'b0000;
        fifo_almost_full = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_pop%0d", i), 8'(pop), 8'h0);
            check($sformatf("stall_st%0d", i), 8'(state), 8'd3);
            tick();
        end
        fifo_almost_full = 4'b0000;
        #1;
        check("resume0", 8'(pop), 8'h8);
        tick();
        check("resume1", 8'(pop), 8'h1);
        tick();

        // Drain to IDLE.
        fifo_empty = 4'hF;
        #1;
        check("drain_pop", 8'(pop), 8'h0);
        tick();
        check("drain_state", 8'(state), 8'd2);
        check("drain_sel", 8'(selector_IDLE), 8'd0);

        // Error is sticky, even with init and data present.
        fifo_error = 4'b0100;
        tick();
        check("err_state", 8'(state), 8'd4);
        check("err_flag", 8'({idle_out, active_out, error_out}), 8'b001);
        fifo_error = 4'b0000;
        init       = 1'b1;
        fifo_empty = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("err_hold%0d", i), 8'(state), 8'd4);
            check($sformatf("err_pop%0d", i), 8'(pop), 8'h0);
            check($sformatf("err_sel%0d", i), 8'(selector_IDLE), 8'd0);
        end
        check("err_ulo", 8'(umbral_low_out), 8'd2);
        #2;
        reset_L = 1'b0;
        #1;
        check("err_rst_state", 8'(state), 8'd0);
        check("err_rst_uhi", 8'(umbral_high_out), 8'd0);
        check("err_rst_flags", 8'({idle_out, active_out, error_out}), 8'd0);

        // Async reset mid-ACTIVE.
        init           = 1'b1;
        umbral_low_in  = 3'd3;
        umbral_high_in = 3'd4;
        fifo_empty     = 4'hF;
        @(negedge clk_1);
        reset_L = 1'b1;
        tick();
        init = 1'b0;
        tick();
        check("bu2_idle", 8'(state), 8'd2);
        check("bu2_ulo", 8'(umbral_low_out), 8'd3);
        fifo_empty = 4'b1100;
        tick();
        check("bu2_act", 8'(state), 8'd3);
        check("bu2_pop", 8'(pop), 8'h1);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_pop", 8'(pop), 8'h0);
        check("async_state", 8'(state), 8'd0);
        check("async_sel", 8'(selector_IDLE), 8'd0);

        // Error takes priority over init while in INIT.
        init       = 1'b1;
        fifo_empty = 4'hF;
        @(negedge clk_1);
        reset_L = 1'b1;
        tick();
        check("pri_init", 8'(state), 8'd1);
        fifo_error = 4'b0001;
        tick();
        check("pri_err", 8'(state), 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
